// File: rtl/sc_regbus_pkg.sv
// Shared types, constants and the address decoder for the register-bus splitter.
package sc_regbus_pkg;

  localparam int unsigned TYP_W   = 10;
  // The decoder works on maximum-size vectors; callers zero-extend into them.
  localparam int unsigned DEC_AW  = 64;
  localparam int unsigned DEC_TGT = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} ch_state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } dec_t;

  // Lowest-indexed target whose masked base matches the address wins.
  function automatic dec_t decode(input logic [DEC_AW-1:0]         adr,
                                  input logic [DEC_TGT*DEC_AW-1:0] base,
                                  input logic [DEC_TGT*DEC_AW-1:0] mask,
                                  input int unsigned               num);
    dec_t d;
    d = '0;
    for (int unsigned i = 0; i < DEC_TGT; i++) begin
      if (!d.hit && (i < num) &&
          ((adr & mask[i*DEC_AW +: DEC_AW]) == base[i*DEC_AW +: DEC_AW])) begin
        d.hit = 1'b1;
        d.idx = 4'(i);
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/sc_regbus_split_ch.sv
// One register-bus channel: decode, latch, forward to the selected target, wait with timeout,
// and return a single-cycle completion upstream.
module sc_regbus_split_ch
  import sc_regbus_pkg::*;
#(
  parameter int unsigned               AW       = 32,
  parameter int unsigned               DW       = 32,
  parameter int unsigned               NUM_TGT  = 4,
  parameter logic [NUM_TGT*AW-1:0]     TGT_BASE = '0,
  parameter logic [NUM_TGT*AW-1:0]     TGT_MASK = '0,
  parameter int unsigned               TMO_CYC  = 256
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [AW-1:0]           i_adr,
  input  logic [TYP_W-1:0]        i_typ,
  input  logic [DW/8-1:0]         i_enb,
  input  logic [DW-1:0]           i_wdat,
  output logic                    o_wat,
  output logic                    o_err,
  output logic [DW-1:0]           o_rdat,
  output logic [AW-1:0]           o_dadr,
  output logic [TYP_W-1:0]        o_dtyp,
  output logic [DW-1:0]           o_dwdat,
  output logic [NUM_TGT*DW/8-1:0] o_denb,
  input  logic [NUM_TGT-1:0]      i_dwat,
  input  logic [NUM_TGT-1:0]      i_derr,
  input  logic [NUM_TGT*DW-1:0]   i_drdat,
  output logic                    o_decerr,
  output logic                    o_tmo
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned SW = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam int unsigned CW = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  ch_state_t r_state, w_state_nxt;

  logic [AW-1:0]    r_adr;
  logic [TYP_W-1:0] r_typ;
  logic [BW-1:0]    r_enb;
  logic [DW-1:0]    r_wdat;
  logic [SW-1:0]    r_sel;
  logic [CW-1:0]    r_cnt;
  logic             r_err;
  logic [DW-1:0]    r_rdat;
  logic             r_decerr;
  logic             r_tmo;

  logic                       w_req;
  logic                       w_latch;
  logic                       w_capture;
  logic                       w_abort;
  logic [DEC_AW-1:0]          w_adr_x;
  logic [DEC_TGT*DEC_AW-1:0]  w_base_x;
  logic [DEC_TGT*DEC_AW-1:0]  w_mask_x;
  dec_t                       w_dec;
  logic [SW-1:0]              w_sel;
  logic [AW-1:0]              w_off;

  assign w_req = (i_enb != '0);

  // Address decode of the live upstream request (only consumed in IDLE).
  always_comb begin
    w_adr_x  = DEC_AW'(i_adr);
    w_base_x = '0;
    w_mask_x = '0;
    for (int i = 0; i < int'(NUM_TGT); i++) begin
      w_base_x[i*DEC_AW +: DEC_AW] = DEC_AW'(TGT_BASE[i*AW +: AW]);
      w_mask_x[i*DEC_AW +: DEC_AW] = DEC_AW'(TGT_MASK[i*AW +: AW]);
    end
    w_dec = decode(w_adr_x, w_base_x, w_mask_x, NUM_TGT);
    w_sel = SW'(w_dec.idx);
    w_off = i_adr & ~TGT_MASK[w_sel*AW +: AW];
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, upstream handshake and downstream byte enables.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    w_abort     = 1'b0;
    o_wat       = 1'b0;
    o_err       = 1'b0;
    o_denb      = '0;
    unique case (r_state)
      IDLE: begin
        o_wat = w_req;
        if (w_req) begin
          w_latch     = 1'b1;
          w_state_nxt = w_dec.hit ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        o_wat = 1'b1;
        o_denb[r_sel*BW +: BW] = r_enb;
        if (!i_dwat[r_sel]) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end else if ((TMO_CYC != 0) && (r_cnt == CNT_LAST)) begin
          w_abort     = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        o_err       = r_err;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Hold the master off while reset is applied so nothing completes.
    if (i_rst) begin
      o_wat = w_req;
    end
  end

  // Request latch, response capture, wait counter and status pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_adr    <= '0;
      r_typ    <= '0;
      r_enb    <= '0;
      r_wdat   <= '0;
      r_sel    <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_rdat   <= '0;
      r_decerr <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      r_decerr <= 1'b0;
      r_tmo    <= 1'b0;
      if (w_latch) begin
        r_adr    <= w_off;
        r_typ    <= i_typ;
        r_enb    <= i_enb;
        r_wdat   <= i_wdat;
        r_sel    <= w_sel;
        r_cnt    <= '0;
        r_err    <= ~w_dec.hit;
        r_decerr <= ~w_dec.hit;
        if (!w_dec.hit) begin
          r_rdat <= '0;
        end
      end else if (w_capture) begin
        r_err  <= i_derr[r_sel];
        r_rdat <= i_derr[r_sel] ? '0 : i_drdat[r_sel*DW +: DW];
      end else if (w_abort) begin
        r_err  <= 1'b1;
        r_tmo  <= 1'b1;
        r_rdat <= '0;
      end else if ((r_state == ISSUE) && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_rdat   = r_rdat;
  assign o_dadr   = r_adr;
  assign o_dtyp   = r_typ;
  assign o_dwdat  = r_wdat;
  assign o_decerr = r_decerr;
  assign o_tmo    = r_tmo;

endmodule

// File: rtl/sc_regbus_split.sv
// Register-bus splitter: one upstream master fanned out to NUM_TGT register targets, with
// independent write and read channels.
module sc_regbus_split
  import sc_regbus_pkg::*;
#(
  parameter int unsigned           AW       = 32,
  parameter int unsigned           DW       = 32,
  parameter int unsigned           NUM_TGT  = 4,
  parameter logic [NUM_TGT*AW-1:0] TGT_BASE = {32'h0000_3000, 32'h0000_2000,
                                               32'h0000_1000, 32'h0000_0000},
  parameter logic [NUM_TGT*AW-1:0] TGT_MASK = {NUM_TGT{32'hFFFF_F000}},
  parameter int unsigned           TMO_CYC  = 256
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [AW-1:0]           U_WADR,
  input  logic [TYP_W-1:0]        U_WTYP,
  input  logic [DW/8-1:0]         U_WENB,
  input  logic [DW-1:0]           U_WDAT,
  output logic                    U_WWAT,
  output logic                    U_WERR,
  input  logic [AW-1:0]           U_RADR,
  input  logic [TYP_W-1:0]        U_RTYP,
  input  logic [DW/8-1:0]         U_RENB,
  output logic [DW-1:0]           U_RDAT,
  output logic                    U_RWAT,
  output logic                    U_RERR,
  output logic [AW-1:0]           D_WADR,
  output logic [TYP_W-1:0]        D_WTYP,
  output logic [DW-1:0]           D_WDAT,
  output logic [NUM_TGT*DW/8-1:0] D_WENB,
  input  logic [NUM_TGT-1:0]      D_WWAT,
  input  logic [NUM_TGT-1:0]      D_WERR,
  output logic [AW-1:0]           D_RADR,
  output logic [TYP_W-1:0]        D_RTYP,
  output logic [NUM_TGT*DW/8-1:0] D_RENB,
  input  logic [NUM_TGT*DW-1:0]   D_RDAT,
  input  logic [NUM_TGT-1:0]      D_RWAT,
  input  logic [NUM_TGT-1:0]      D_RERR,
  output logic                    W_DECERR,
  output logic                    W_TMO,
  output logic                    R_DECERR,
  output logic                    R_TMO
);

  logic [DW-1:0] w_unused_wr_rdat;
  logic [DW-1:0] w_unused_rd_wdat;

  // Write channel; the read-data path is tied off.
  sc_regbus_split_ch #(
    .AW      (AW),
    .DW      (DW),
    .NUM_TGT (NUM_TGT),
    .TGT_BASE(TGT_BASE),
    .TGT_MASK(TGT_MASK),
    .TMO_CYC (TMO_CYC)
  ) u_wr (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_adr   (U_WADR),
    .i_typ   (U_WTYP),
    .i_enb   (U_WENB),
    .i_wdat  (U_WDAT),
    .o_wat   (U_WWAT),
    .o_err   (U_WERR),
    .o_rdat  (w_unused_wr_rdat),
    .o_dadr  (D_WADR),
    .o_dtyp  (D_WTYP),
    .o_dwdat (D_WDAT),
    .o_denb  (D_WENB),
    .i_dwat  (D_WWAT),
    .i_derr  (D_WERR),
    .i_drdat ('0),
    .o_decerr(W_DECERR),
    .o_tmo   (W_TMO)
  );

  // Read channel; there is no write data to forward.
  sc_regbus_split_ch #(
    .AW      (AW),
    .DW      (DW),
    .NUM_TGT (NUM_TGT),
    .TGT_BASE(TGT_BASE),
    .TGT_MASK(TGT_MASK),
    .TMO_CYC (TMO_CYC)
  ) u_rd (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_adr   (U_RADR),
    .i_typ   (U_RTYP),
    .i_enb   (U_RENB),
    .i_wdat  ('0),
    .o_wat   (U_RWAT),
    .o_err   (U_RERR),
    .o_rdat  (U_RDAT),
    .o_dadr  (D_RADR),
    .o_dtyp  (D_RTYP),
    .o_dwdat (w_unused_rd_wdat),
    .o_denb  (D_RENB),
    .i_dwat  (D_RWAT),
    .i_derr  (D_RERR),
    .i_drdat (D_RDAT),
    .o_decerr(R_DECERR),
    .o_tmo   (R_TMO)
  );

endmodule

// File: tb/tb_sc_regbus_split.sv
// Scoreboard bench for sc_regbus_split: stimulus queues expected completions, monitors check them.
module tb_sc_regbus_split;

  logic         CLK = 1'b0;
  logic         RST;
  logic [31:0]  U_WADR, U_WDAT, U_RADR, U_RDAT;
  logic [9:0]   U_WTYP, U_RTYP;
  logic [3:0]   U_WENB, U_RENB;
  logic         U_WWAT, U_WERR, U_RWAT, U_RERR;
  logic [31:0]  D_WADR, D_WDAT, D_RADR;
  logic [9:0]   D_WTYP, D_RTYP;
  logic [15:0]  D_WENB, D_RENB;
  logic [3:0]   D_WWAT, D_WERR, D_RWAT, D_RERR;
  logic [127:0] D_RDAT;
  logic         W_DECERR, W_TMO, R_DECERR, R_TMO;

  sc_regbus_split #(.TMO_CYC(16)) dut (
    .CLK(CLK), .RST(RST),
    .U_WADR(U_WADR), .U_WTYP(U_WTYP), .U_WENB(U_WENB), .U_WDAT(U_WDAT),
    .U_WWAT(U_WWAT), .U_WERR(U_WERR),
    .U_RADR(U_RADR), .U_RTYP(U_RTYP), .U_RENB(U_RENB), .U_RDAT(U_RDAT),
    .U_RWAT(U_RWAT), .U_RERR(U_RERR),
    .D_WADR(D_WADR), .D_WTYP(D_WTYP), .D_WDAT(D_WDAT), .D_WENB(D_WENB),
    .D_WWAT(D_WWAT), .D_WERR(D_WERR),
    .D_RADR(D_RADR), .D_RTYP(D_RTYP), .D_RENB(D_RENB), .D_RDAT(D_RDAT),
    .D_RWAT(D_RWAT), .D_RERR(D_RERR),
    .W_DECERR(W_DECERR), .W_TMO(W_TMO), .R_DECERR(R_DECERR), .R_TMO(R_TMO)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Target models: each target waits a set number of enabled cycles before releasing.
  int          wwait[4];
  int          rwait[4];
  int          wecnt[4];
  int          recnt[4];
  logic [31:0] rdat_m[4];
  logic [3:0]  werr_m, rerr_m;
  int          renb0_cnt = 0;

  always @(posedge CLK) begin
    for (int t = 0; t < 4; t++) begin
      wecnt[t] <= (D_WENB[t*4 +: 4] != 0) ? wecnt[t] + 1 : 0;
      recnt[t] <= (D_RENB[t*4 +: 4] != 0) ? recnt[t] + 1 : 0;
    end
  end

  always_comb begin
    D_WWAT = '0;
    D_RWAT = '0;
    D_RDAT = '0;
    for (int t = 0; t < 4; t++) begin
      D_WWAT[t] = (D_WENB[t*4 +: 4] != 0) && (wecnt[t] < wwait[t]);
      D_RWAT[t] = (D_RENB[t*4 +: 4] != 0) && (recnt[t] < rwait[t]);
      D_RDAT[t*32 +: 32] = rdat_m[t];
    end
  end
  assign D_WERR = werr_m;
  assign D_RERR = rerr_m;

  always @(negedge CLK) if (D_RENB[3:0] != 0) renb0_cnt++;

  typedef struct {
    logic        err;
    logic [31:0] rdat;
    int          lat;
    logic        dec;
    logic        tmo;
    int          t0;
  } exp_t;

  exp_t wq[$];
  exp_t rq[$];

  function automatic exp_t mk(input logic err, input logic [31:0] rdat, input int lat,
                              input logic dec, input logic tmo);
    exp_t e;
    e.err = err; e.rdat = rdat; e.lat = lat; e.dec = dec; e.tmo = tmo; e.t0 = 0;
    return e;
  endfunction

  // Write completion monitor.
  always @(negedge CLK) begin : mon_wr
    exp_t e;
    if (U_WENB != 0 && !U_WWAT) begin
      if (wq.size() == 0) begin
        total++; bad++;
        $display("FAIL wr_unexpected: completion with nothing expected (cycle %0d)", cyc);
      end else begin
        e = wq.pop_front();
        chk("wr_err", 64'(U_WERR), 64'(e.err));
        chk("wr_lat", 64'(cyc - e.t0), 64'(e.lat));
        chk("wr_decerr", 64'(W_DECERR), 64'(e.dec));
        chk("wr_tmo", 64'(W_TMO), 64'(e.tmo));
      end
    end
  end

  // Read completion monitor.
  always @(negedge CLK) begin : mon_rd
    exp_t e;
    if (U_RENB != 0 && !U_RWAT) begin
      if (rq.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected: completion with nothing expected (cycle %0d)", cyc);
      end else begin
        e = rq.pop_front();
        chk("rd_err", 64'(U_RERR), 64'(e.err));
        chk("rd_data", 64'(U_RDAT), 64'(e.rdat));
        chk("rd_lat", 64'(cyc - e.t0), 64'(e.lat));
        chk("rd_decerr", 64'(R_DECERR), 64'(e.dec));
        chk("rd_tmo", 64'(R_TMO), 64'(e.tmo));
      end
    end
  end

  task automatic wr_xfer(input logic [31:0] adr, input logic [31:0] dat, input exp_t e);
    exp_t it;
    bit   done;
    @(posedge CLK); #1;
    U_WADR = adr; U_WDAT = dat; U_WTYP = 10'h1; U_WENB = 4'hF;
    it = e; it.t0 = cyc; wq.push_back(it);
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge CLK);
      if (!U_WWAT) done = 1'b1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL wr_timeout: no completion for adr %0h", adr);
    end
    @(posedge CLK); #1;
    U_WENB = '0;
  endtask

  task automatic rd_xfer(input logic [31:0] adr, input exp_t e);
    exp_t it;
    bit   done;
    @(posedge CLK); #1;
    U_RADR = adr; U_RTYP = 10'h2; U_RENB = 4'hF;
    it = e; it.t0 = cyc; rq.push_back(it);
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge CLK);
      if (!U_RWAT) done = 1'b1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL rd_timeout: no completion for adr %0h", adr);
    end
    @(posedge CLK); #1;
    U_RENB = '0;
  endtask

  initial begin
    int n0;
    RST = 1'b1;
    U_WADR = '0; U_WDAT = '0; U_WTYP = '0; U_WENB = '0;
    U_RADR = '0; U_RTYP = '0; U_RENB = '0;
    werr_m = '0; rerr_m = '0;
    for (int t = 0; t < 4; t++) begin
      wwait[t] = 0; rwait[t] = 0; rdat_m[t] = '0;
    end
    rdat_m[0] = 32'hCAFE_F00D;
    rdat_m[1] = 32'h0000_0055;
    rdat_m[2] = 32'h1234_5678;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    // Reset state.
    @(negedge CLK);
    chk("rst_wenb", 64'(D_WENB), 64'h0);
    chk("rst_renb", 64'(D_RENB), 64'h0);
    chk("rst_wadr", 64'(D_WADR), 64'h0);
    chk("rst_rdat", 64'(U_RDAT), 64'h0);
    chk("rst_werr", 64'(U_WERR), 64'h0);
    chk("rst_rerr", 64'(U_RERR), 64'h0);
    chk("rst_pulses", 64'({W_DECERR, W_TMO, R_DECERR, R_TMO}), 64'h0);
    chk("rst_wwat", 64'(U_WWAT), 64'h0);

    // Zero-wait write to target 1.
    fork
      wr_xfer(32'h1004, 32'hDEAD_BEEF, mk(1'b0, 32'h0, 2, 1'b0, 1'b0));
      begin
        @(posedge CLK); #1;
        @(negedge CLK);
        @(negedge CLK);
        chk("t1_denb", 64'(D_WENB), 64'h00F0);
        chk("t1_dadr", 64'(D_WADR), 64'h004);
        chk("t1_dwdat", 64'(D_WDAT), 64'hDEAD_BEEF);
      end
    join

    // Read with three target wait cycles.
    rwait[2] = 3;
    fork
      rd_xfer(32'h2008, mk(1'b0, 32'h1234_5678, 5, 1'b0, 1'b0));
      begin
        @(posedge CLK); #1;
        @(negedge CLK);
        @(negedge CLK);
        chk("t2_renb", 64'(D_RENB), 64'h0F00);
        chk("t2_radr", 64'(D_RADR), 64'h008);
      end
    join
    rwait[2] = 0;

    // Unmapped write.
    fork
      wr_xfer(32'h8000, 32'h1111_2222, mk(1'b1, 32'h0, 1, 1'b1, 1'b0));
      begin
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("t3_denb_c0", 64'(D_WENB), 64'h0);
        @(negedge CLK);
        chk("t3_denb_c1", 64'(D_WENB), 64'h0);
      end
    join

    // Target error on read returns zero data.
    rerr_m[1] = 1'b1;
    rd_xfer(32'h1000, mk(1'b1, 32'h0, 2, 1'b0, 1'b0));
    rerr_m[1] = 1'b0;

    // Read timeout: target 0 never releases.
    rwait[0] = 1000;
    n0 = renb0_cnt;
    rd_xfer(32'h0010, mk(1'b1, 32'h0, 17, 1'b0, 1'b1));
    chk("t4_renb_cycles", 64'(renb0_cnt - n0), 64'd16);
    rwait[0] = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("t4_late_tmo", 64'(R_TMO), 64'h0);
      chk("t4_late_renb", 64'(D_RENB), 64'h0);
    end

    // Concurrent write (zero wait) and read (two waits) to target 0.
    rwait[0] = 2;
    fork
      wr_xfer(32'h0020, 32'hA5A5_0001, mk(1'b0, 32'h0, 2, 1'b0, 1'b0));
      rd_xfer(32'h0030, mk(1'b0, 32'hCAFE_F00D, 4, 1'b0, 1'b0));
    join
    rwait[0] = 0;

    // Reset while a write sits in ISSUE.
    wwait[3] = 1000;
    @(posedge CLK); #1;
    U_WADR = 32'h3010; U_WDAT = 32'h7777_8888; U_WTYP = 10'h3; U_WENB = 4'hF;
    repeat (3) @(negedge CLK);
    chk("t6_denb_issue", 64'(D_WENB), 64'hF000);
    @(posedge CLK); #1 RST = 1'b1;
    @(negedge CLK);
    chk("t6_wwat_in_rst", 64'(U_WWAT), 64'h1);
    @(posedge CLK); #1;
    RST = 1'b0; U_WENB = '0;
    @(negedge CLK);
    chk("t6_denb_after", 64'(D_WENB), 64'h0);
    chk("t6_wadr_after", 64'(D_WADR), 64'h0);
    chk("t6_wdat_after", 64'(D_WDAT), 64'h0);
    chk("t6_wwat_after", 64'(U_WWAT), 64'h0);
    wwait[3] = 0;
    wr_xfer(32'h3008, 32'h0BAD_CAFE, mk(1'b0, 32'h0, 2, 1'b0, 1'b0));

    repeat (3) @(negedge CLK);
    chk("wq_drained", 64'(wq.size()), 64'h0);
    chk("rq_drained", 64'(rq.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/sc_regbus_split.md
Name: sc_regbus_split

Overview:
- Register-bus splitter: one upstream register-bus master (bus IP side) fans out to NUM_TGT register targets.
- Write and read channels are independent; each decodes its address against per-target base/mask and forwards the transfer.
- Unmapped accesses and targets that never release wait are converted to bus errors.
- Sits between the bus IP and a group of peripheral register blocks. It is a generalised successor to the fixed 32-bit point-to-point register bus, adding width parameters, fan-out, decode and timeout.

Parameters:
- AW, 32, address width.
- DW, 32, data width; multiple of 8; byte-enable width is DW/8.
- NUM_TGT, 4, number of downstream targets (1..16).
- TGT_BASE, {0x3000,0x2000,0x1000,0x0000}, packed NUM_TGT*AW base addresses; target i is at slice i.
- TGT_MASK, all 0xFFFF_F000, packed NUM_TGT*AW decode masks.
- TMO_CYC, 256, wait-cycle limit per transfer; 0 disables the timeout.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- U_WADR/U_WTYP/U_WENB/U_WDAT  in  AW/10/DW/8/DW  upstream write request.
- U_WWAT/U_WERR  out  1/1  upstream write wait and error.
- U_RADR/U_RTYP/U_RENB  in  AW/10/DW/8  upstream read request.
- U_RDAT  out  DW  upstream read data.
- U_RWAT/U_RERR  out  1/1  upstream read wait and error.
- D_WADR/D_WTYP/D_WDAT  out  AW/10/DW  write request, broadcast to all targets; address is the offset.
- D_WENB  out  NUM_TGT*DW/8  per-target write byte enables.
- D_WWAT/D_WERR  in  NUM_TGT/NUM_TGT  per-target write wait and error.
- D_RADR/D_RTYP  out  AW/10  read request, broadcast to all targets.
- D_RENB  out  NUM_TGT*DW/8  per-target read byte enables.
- D_RDAT  in  NUM_TGT*DW  per-target read data.
- D_RWAT/D_RERR  in  NUM_TGT/NUM_TGT  per-target read wait and error.
- W_DECERR/W_TMO/R_DECERR/R_TMO  out  1 each  one-cycle status pulses.

Behaviour:
- Bus protocol:
  - A request is present when xENB != 0.
  - The master holds ADR/TYP/ENB/WDAT stable while xWAT=1.
  - A transfer completes on the cycle xENB != 0 and xWAT=0; xERR and RDAT are valid in that cycle only.
- Decode:
  - Target i hits when (ADR & TGT_MASK[i]) == TGT_BASE[i]. If several targets hit, the lowest index wins.
  - Forwarded address is ADR & ~TGT_MASK[sel].
- Per-channel FSM, one instance for write and one for read:
  - IDLE:
    - U_xWAT = (U_xENB != 0), combinational.
    - On a request, latch ADR/TYP/ENB/WDAT and sel, and clear the counter.
    - If the address hits, go to ISSUE; otherwise go to RESP with err=1 and pulse xDECERR.
  - ISSUE:
    - Drive D_xENB slice sel with the latched ENB; all other slices are 0.
    - If D_xWAT[sel]=0: capture D_xERR[sel] and, for reads, D_RDAT[sel]; go to RESP.
    - Else if TMO_CYC != 0 and cnt == TMO_CYC-1: drop D_xENB, go to RESP with err=1, pulse xTMO.
    - Else cnt++.
  - RESP: U_xWAT=0 and U_xERR=err; U_RDAT holds the captured data, or 0 on error. Go to IDLE next cycle.
- Latency: a zero-wait target completes at upstream cycle 2 after request cycle 0. Each target wait cycle adds 1. Decode error completes at cycle 1.
- Timeout: a target may hold wait for at most TMO_CYC-1 ISSUE cycles. After an abort, a late D_xWAT release or D_xERR from that target is ignored.
- D_xADR/TYP/WDAT are registered and hold their last value after completion. D_xENB is 0 in every state except ISSUE.
- The write and read channels run fully concurrently, including to the same target.
- Counter width is $clog2(TMO_CYC+1); it saturates and never wraps.
- Reset (synchronous, any state):
  - Next cycle: FSM=IDLE, D_xENB=0, D_xADR=0, D_xTYP=0, D_WDAT=0, U_RDAT=0, U_xERR=0, pulses=0, cnt=0.
  - A transfer in flight is dropped with no completion.
  - U_xWAT=1 during RST while U_xENB != 0.

Decomposition:
- Package sc_regbus_pkg:
  - constant TYP_W=10;
  - enum ch_state_t {IDLE, ISSUE, RESP};
  - function decode(adr, base, mask) returning hit and index.
- Sub-module sc_regbus_split_ch: one channel FSM with counter and latch. It is instantiated twice; in the write instance the RDAT path is tied off.

Test Plan:
- Write 0x1004, WDAT 0xDEADBEEF, ENB 0xF; target 1 has zero wait -> cycle 1: D_WENB[7:4]=0xF, D_WADR=0x004; cycle 2: U_WWAT=0, U_WERR=0.
- Read 0x2008; target 2 holds RWAT for 3 cycles, RDAT=0x12345678 -> completion at cycle 5 with U_RDAT=0x12345678, U_RERR=0.
- Write 0x8000 (unmapped) -> D_WENB stays 0; cycle 1: U_WWAT=0, U_WERR=1, W_DECERR pulse.
- TMO_CYC=16; target 0 holds RWAT forever -> D_RENB asserted 16 cycles then 0; next cycle U_RERR=1, R_TMO pulse; a later RWAT drop is ignored.
- Concurrent write and read to target 0 (write zero-wait, read 2-wait) -> write completes at cycle 2, read at cycle 4, no interference.
- RST asserted during ISSUE -> next cycle D_WENB=0, FSM IDLE; a new request after RST completes normally.
